// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl_pkg
// Purpose  : Shared definitions for the pipeline stall/flush controller:
//            control-vector bit indices, canned control words, FSM state
//            encodings and the default exception vector.
// Revision : 1.0 - initial release
// ============================================================================
package pipeline_ctrl_pkg;

  // Bit positions shared by the stall and flush vectors.
  localparam int STALL_PC    = 0;
  localparam int STALL_IFID  = 1;
  localparam int STALL_IDEX  = 2;
  localparam int STALL_EXMEM = 3;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0380;

  // Freeze every register.
  localparam logic [3:0] c_stall_all = 4'b1111;
  // Hold PC and IF/ID, bubble into ID/EX (EX/MEM bit is 0).
  localparam logic [3:0] c_stall_load_use =
    4'((1 << STALL_PC) | (1 << STALL_IFID) | (1 << STALL_IDEX));
  // Kill everything younger than MEM; the PC itself is redirected, not cleared.
  localparam logic [3:0] c_flush_exc =
    4'((1 << STALL_IFID) | (1 << STALL_IDEX) | (1 << STALL_EXMEM));
  // Kill the wrong-path fetch sitting in IF/ID.
  localparam logic [3:0] c_flush_branch = 4'(1 << STALL_IFID);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MDU_WAIT  = 2'd1,
    ST_EXC_FLUSH = 2'd2
  } ctrl_state_e;

endpackage
`default_nettype wire

// File: rtl/pipeline_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl_if
// Purpose  : Bundle of hazard inputs and control outputs between the pipeline
//            datapath (master) and the stall/flush controller (slave).
// Signals  : id_rs/id_rt/id_uses_rt/id_branch_taken  - ID stage status
//            ex_mem_read/ex_dst_reg/ex_mdu_start      - EX stage status
//            mem_req/mem_ready/mem_exc_valid          - MEM stage status
//            stall_C/flush_C                          - per-register control
//            pc_redirect/pc_redirect_addr             - exception redirect
//            mdu_done/mdu_abort                       - divider status
// Revision : 1.0 - initial release
// ============================================================================
interface pipeline_ctrl_if;
  import pipeline_ctrl_pkg::*;

  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic        id_branch_taken;
  logic        ex_mem_read;
  logic [4:0]  ex_dst_reg;
  logic        ex_mdu_start;
  logic        mem_req;
  logic        mem_ready;
  logic        mem_exc_valid;
  logic [3:0]  stall_C;
  logic [3:0]  flush_C;
  logic        pc_redirect;
  logic [31:0] pc_redirect_addr;
  logic        mdu_done;
  logic        mdu_abort;

  modport master (
    output id_rs, id_rt, id_uses_rt, id_branch_taken,
    output ex_mem_read, ex_dst_reg, ex_mdu_start,
    output mem_req, mem_ready, mem_exc_valid,
    input  stall_C, flush_C, pc_redirect, pc_redirect_addr,
    input  mdu_done, mdu_abort
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, id_branch_taken,
    input  ex_mem_read, ex_dst_reg, ex_mdu_start,
    input  mem_req, mem_ready, mem_exc_valid,
    output stall_C, flush_C, pc_redirect, pc_redirect_addr,
    output mdu_done, mdu_abort
  );

endinterface
`default_nettype wire

// File: rtl/pipeline_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module   : hazard_detect
// Purpose  : Combinational load-use detector. Flags when the load in EX
//            writes a register the ID instruction is about to read.
// Ports    : i_ex_mem_read  - EX instruction is a load
//            i_ex_dst_reg   - EX destination register
//            i_id_rs/i_id_rt- ID source registers
//            i_id_uses_rt   - ID instruction actually reads rt
//            o_load_use     - hazard present this cycle
// Revision : 1.0 - initial release
// ============================================================================
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic       i_ex_mem_read,
  input  logic [4:0] i_ex_dst_reg,
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  input  logic       i_id_uses_rt,
  output logic       o_load_use
);

  logic w_rs_match;
  logic w_rt_match;

  assign w_rs_match = (i_ex_dst_reg == i_id_rs);
  assign w_rt_match = i_id_uses_rt && (i_ex_dst_reg == i_id_rt);

  // r0 is hardwired to zero, so a load targeting it never produces a value.
  assign o_load_use = i_ex_mem_read && (i_ex_dst_reg != 5'd0) &&
                      (w_rs_match || w_rt_match);

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl
// Purpose  : Central stall/flush controller for the five-stage pipeline.
//            Prioritises exceptions, memory wait states, divider occupancy,
//            load-use hazards and taken branches into one control word.
// Ports    : clk, rst (async, active-high)
//            bus       - pipeline_ctrl_if.slave (hazard inputs, control out)
// Params   : MDU_CYCLES - stalled cycles per divide (>= 2)
//            EXC_VECTOR - exception handler address
// Config   : PIPE_CTRL_MDU_EN - compiles in the divider wait state, counter,
//            mdu_done and mdu_abort; otherwise ex_mdu_start is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int          MDU_CYCLES = 32,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
)
(
  input  logic            clk,
  input  logic            rst,
  pipeline_ctrl_if.slave  bus
);

  ctrl_state_e r_state;

  logic        w_load_use;
  logic        w_mem_wait;
  logic        w_exc_take;
  logic        w_mdu_busy;
  logic        w_mdu_start;
  logic [3:0]  w_stall;
  logic [3:0]  w_flush;
  logic        w_redirect;
  logic [31:0] w_redirect_addr;
  logic        w_abort;

  hazard_detect u_hazard_detect (
    .i_ex_mem_read (bus.ex_mem_read),
    .i_ex_dst_reg  (bus.ex_dst_reg),
    .i_id_rs       (bus.id_rs),
    .i_id_rt       (bus.id_rt),
    .i_id_uses_rt  (bus.id_uses_rt),
    .o_load_use    (w_load_use)
  );

  assign w_mem_wait = bus.mem_req && !bus.mem_ready;
  // The exception already being flushed must not re-trigger a redirect.
  assign w_exc_take = bus.mem_exc_valid && (r_state != ST_EXC_FLUSH);

`ifdef PIPE_CTRL_MDU_EN
  localparam int CNT_W = $clog2(MDU_CYCLES);
  // The start cycle and the zero-count cycle are both stalled, hence -2.
  localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(MDU_CYCLES - 2);

  logic [CNT_W-1:0] r_cnt;
  logic             r_mdu_done;

  assign w_mdu_busy  = (r_state == ST_MDU_WAIT);
  assign w_mdu_start = (r_state == ST_IDLE) && bus.ex_mdu_start;
  assign bus.mdu_done = r_mdu_done;
`else
  logic w_unused;
  assign w_unused     = bus.ex_mdu_start ^ MDU_CYCLES[0];
  assign w_mdu_busy   = 1'b0;
  assign w_mdu_start  = 1'b0;
  assign bus.mdu_done = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
`ifdef PIPE_CTRL_MDU_EN
      r_cnt      <= '0;
      r_mdu_done <= 1'b0;
`endif
    end else begin
`ifdef PIPE_CTRL_MDU_EN
      r_mdu_done <= 1'b0;
`endif
      case (r_state)
        ST_EXC_FLUSH: r_state <= ST_IDLE;
`ifdef PIPE_CTRL_MDU_EN
        ST_MDU_WAIT: begin
          if (w_exc_take) begin
            r_state <= ST_EXC_FLUSH;
            r_cnt   <= '0;
          end else if (!w_mem_wait) begin
            // A memory wait freezes the divider along with the pipeline.
            if (r_cnt == '0) begin
              r_state    <= ST_IDLE;
              r_mdu_done <= 1'b1;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
        end
`endif
        default: begin
          if (w_exc_take) begin
            r_state <= ST_EXC_FLUSH;
          end
`ifdef PIPE_CTRL_MDU_EN
          else if (bus.ex_mdu_start) begin
            r_state <= ST_MDU_WAIT;
            r_cnt   <= C_CNT_LOAD;
          end
`endif
          else begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // Priority chain; a taken branch is dropped under any stall because ID
  // will present it again once the pipeline moves.
  always_comb begin
    w_stall         = '0;
    w_flush         = '0;
    w_redirect      = 1'b0;
    w_redirect_addr = '0;
    w_abort         = 1'b0;
    if (!rst) begin
      if (r_state == ST_EXC_FLUSH) begin
        w_flush = c_flush_exc;
      end else if (bus.mem_exc_valid) begin
        w_flush         = c_flush_exc;
        w_redirect      = 1'b1;
        w_redirect_addr = EXC_VECTOR;
        w_abort         = w_mdu_busy;
      end else if (w_mem_wait || w_mdu_busy || w_mdu_start) begin
        w_stall = c_stall_all;
      end else if (w_load_use) begin
        w_stall = c_stall_load_use;
      end else if (bus.id_branch_taken) begin
        w_flush = c_flush_branch;
      end
    end
  end

  assign bus.stall_C          = w_stall;
  assign bus.flush_C          = w_flush;
  assign bus.pc_redirect      = w_redirect;
  assign bus.pc_redirect_addr = w_redirect_addr;
  assign bus.mdu_abort        = w_abort;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_ctrl
// Purpose  : Self-checking bench for pipeline_ctrl. A cycle-level model of
//            the control rules is compared against the DUT every cycle, and
//            directed scenarios pin literal expected values. Divider tests
//            are active when PIPE_CTRL_MDU_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

  localparam int          MDU_CYC = 4;
  localparam logic [31:0] EXC_VEC = 32'h0000_0380;
`ifdef PIPE_CTRL_MDU_EN
  localparam bit MDU_EN = 1'b1;
`else
  localparam bit MDU_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeline_ctrl_if u_if ();

  pipeline_ctrl #(.MDU_CYCLES(MDU_CYC), .EXC_VECTOR(EXC_VEC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_div_left;   // divide cycles still owed (excluding memory-wait ones)
  bit m_exc_flush;  // the cycle after an exception
  bit m_done;       // first cycle after a divide finished

  function automatic bit f_mem_wait();
    return u_if.mem_req && !u_if.mem_ready;
  endfunction

  function automatic bit f_load_use();
    return u_if.ex_mem_read && (u_if.ex_dst_reg != 5'd0) &&
           ((u_if.ex_dst_reg == u_if.id_rs) ||
            (u_if.id_uses_rt && (u_if.ex_dst_reg == u_if.id_rt)));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_div_left  <= 0;
      m_exc_flush <= 1'b0;
      m_done      <= 1'b0;
    end else begin
      m_done      <= 1'b0;
      m_exc_flush <= 1'b0;
      if (!m_exc_flush) begin
        if (u_if.mem_exc_valid) begin
          m_exc_flush <= 1'b1;
          m_div_left  <= 0;
        end else if (m_div_left > 0) begin
          if (!f_mem_wait()) begin
            m_div_left <= m_div_left - 1;
            if (m_div_left == 1) m_done <= 1'b1;
          end
        end else if (MDU_EN && u_if.ex_mdu_start) begin
          m_div_left <= MDU_CYC - 1;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always begin
    logic [3:0]  e_stall, e_flush;
    logic        e_redir, e_abort, e_done;
    logic [31:0] e_addr;
    @(negedge clk);
    #2;
    e_stall = '0; e_flush = '0; e_redir = 1'b0; e_abort = 1'b0; e_addr = '0;
    e_done  = m_done;
    if (rst) begin
      e_done = 1'b0;
    end else if (m_exc_flush) begin
      e_flush = 4'b1110;
    end else if (u_if.mem_exc_valid) begin
      e_flush = 4'b1110;
      e_redir = 1'b1;
      e_addr  = EXC_VEC;
      e_abort = (m_div_left > 0);
    end else if (f_mem_wait() || (m_div_left > 0) || (MDU_EN && u_if.ex_mdu_start)) begin
      e_stall = 4'b1111;
    end else if (f_load_use()) begin
      e_stall = 4'b0111;
    end else if (u_if.id_branch_taken) begin
      e_flush = 4'b0010;
    end
    chk("model_stall",  u_if.stall_C,          e_stall);
    chk("model_flush",  u_if.flush_C,          e_flush);
    chk("model_redir",  u_if.pc_redirect,      e_redir);
    chk("model_addr",   u_if.pc_redirect_addr, e_addr);
    chk("model_done",   u_if.mdu_done,         e_done);
    chk("model_abort",  u_if.mdu_abort,        e_abort);
  end

  // ---------------- stimulus helpers ----------------
  task automatic quiet();
    u_if.id_rs           = 5'd0;
    u_if.id_rt           = 5'd0;
    u_if.id_uses_rt      = 1'b0;
    u_if.id_branch_taken = 1'b0;
    u_if.ex_mem_read     = 1'b0;
    u_if.ex_dst_reg      = 5'd0;
    u_if.ex_mdu_start    = 1'b0;
    u_if.mem_req         = 1'b0;
    u_if.mem_ready       = 1'b1;
    u_if.mem_exc_valid   = 1'b0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    quiet();
  endtask

  task automatic set_load_use(input logic [4:0] dst);
    u_if.ex_mem_read = 1'b1;
    u_if.ex_dst_reg  = dst;
    u_if.id_rs       = 5'd5;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_stall"}, u_if.stall_C,          32'h0);
    chk({name, "_flush"}, u_if.flush_C,          32'h0);
    chk({name, "_redir"}, u_if.pc_redirect,      32'h0);
    chk({name, "_addr"},  u_if.pc_redirect_addr, 32'h0);
    chk({name, "_done"},  u_if.mdu_done,         32'h0);
    chk({name, "_abort"}, u_if.mdu_abort,        32'h0);
  endtask

`ifdef PIPE_CTRL_MDU_EN
  // Start a divide and count stalled cycles until EX/MEM is released.
  task automatic run_div(input string name, input int wait_at, input int exp_n);
    int n;
    next_cycle();
    u_if.ex_mdu_start = 1'b1;
    #2;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (u_if.stall_C != 4'b1111) break;
      n++;
      next_cycle();
      if (k + 1 == wait_at) begin
        u_if.mem_req   = 1'b1;
        u_if.mem_ready = 1'b0;
      end
      #2;
    end
    chk({name, "_cycles"}, n, exp_n);
    chk({name, "_done"},   u_if.mdu_done, 32'h1);
    chk({name, "_stall"},  u_if.stall_C,  32'h0);
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    quiet();
    rst = 1'b1;
    @(negedge clk); #2;
    chk_all_zero("in_reset");
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk_all_zero("post_reset");

    // Load-use through rs.
    next_cycle(); set_load_use(5'd5); #2;
    chk("lu_rs_stall", u_if.stall_C, 32'h7);
    chk("lu_rs_flush", u_if.flush_C, 32'h0);
    next_cycle(); #2;
    chk("lu_cleared", u_if.stall_C, 32'h0);

    // r0 destination never hazards, even when rs is also r0.
    next_cycle(); set_load_use(5'd0); u_if.id_rs = 5'd0; #2;
    chk("lu_r0_stall", u_if.stall_C, 32'h0);

    // Load-use through rt, only when rt is actually read.
    next_cycle(); set_load_use(5'd7); u_if.id_rs = 5'd3; u_if.id_rt = 5'd7;
    u_if.id_uses_rt = 1'b1; #2;
    chk("lu_rt_stall", u_if.stall_C, 32'h7);
    next_cycle(); set_load_use(5'd7); u_if.id_rs = 5'd3; u_if.id_rt = 5'd7; #2;
    chk("lu_rt_unused", u_if.stall_C, 32'h0);

    // Taken branch alone, then masked by a load-use stall.
    next_cycle(); u_if.id_branch_taken = 1'b1; #2;
    chk("br_flush", u_if.flush_C, 32'h2);
    chk("br_stall", u_if.stall_C, 32'h0);
    next_cycle(); u_if.id_branch_taken = 1'b1; set_load_use(5'd5); #2;
    chk("br_lu_stall", u_if.stall_C, 32'h7);
    chk("br_lu_flush", u_if.flush_C, 32'h0);

    // Memory wait outranks load-use.
    for (int i = 0; i < 3; i++) begin
      next_cycle(); set_load_use(5'd5);
      u_if.mem_req = 1'b1; u_if.mem_ready = 1'b0; #2;
      chk("memwait_stall", u_if.stall_C, 32'hF);
    end
    next_cycle(); set_load_use(5'd5); u_if.mem_req = 1'b1; #2;
    chk("memwait_then_lu", u_if.stall_C, 32'h7);

    // Exception from IDLE; a repeat in EXC_FLUSH is ignored.
    next_cycle(); u_if.mem_exc_valid = 1'b1; u_if.mem_req = 1'b1; u_if.mem_ready = 1'b0; #2;
    chk("exc_flush", u_if.flush_C, 32'hE);
    chk("exc_stall", u_if.stall_C, 32'h0);
    chk("exc_redir", u_if.pc_redirect, 32'h1);
    chk("exc_addr",  u_if.pc_redirect_addr, 32'h380);
    chk("exc_abort", u_if.mdu_abort, 32'h0);
    next_cycle(); u_if.mem_exc_valid = 1'b1; #2;
    chk("excf_flush", u_if.flush_C, 32'hE);
    chk("excf_redir", u_if.pc_redirect, 32'h0);
    next_cycle(); #2;
    chk("exc_idle_flush", u_if.flush_C, 32'h0);

`ifdef PIPE_CTRL_MDU_EN
    run_div("div_plain", -1, MDU_CYC);
    run_div("div_memwait", 2, MDU_CYC + 1);

    // Exception while the divider is busy.
    next_cycle(); u_if.ex_mdu_start = 1'b1;
    next_cycle(); u_if.mem_exc_valid = 1'b1; #2;
    chk("div_exc_flush", u_if.flush_C, 32'hE);
    chk("div_exc_redir", u_if.pc_redirect, 32'h1);
    chk("div_exc_addr",  u_if.pc_redirect_addr, 32'h380);
    chk("div_exc_abort", u_if.mdu_abort, 32'h1);
    chk("div_exc_stall", u_if.stall_C, 32'h0);
    next_cycle(); #2;
    chk("div_excf_flush", u_if.flush_C, 32'hE);
    chk("div_excf_redir", u_if.pc_redirect, 32'h0);
    next_cycle(); #2;
    chk("div_exc_idle_stall", u_if.stall_C, 32'h0);
    chk("div_exc_no_done",    u_if.mdu_done, 32'h0);

    // Asynchronous reset in the middle of a divide.
    next_cycle(); u_if.ex_mdu_start = 1'b1;
    next_cycle(); #3;
    chk("div_busy_before_rst", u_if.stall_C, 32'hF);
    rst = 1'b1; #1;
    chk_all_zero("div_async_rst");
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk_all_zero("div_rst_release");
    run_div("div_after_rst", -1, MDU_CYC);
`else
    // Divider compiled out: a start request has no effect.
    next_cycle(); u_if.ex_mdu_start = 1'b1; #2;
    chk("nodiv_stall", u_if.stall_C, 32'h0);
    chk("nodiv_done",  u_if.mdu_done, 32'h0);
    next_cycle(); #2;
    chk("nodiv_after_stall", u_if.stall_C, 32'h0);
`endif

    // Asynchronous reset in EXC_FLUSH.
    next_cycle(); u_if.mem_exc_valid = 1'b1;
    next_cycle(); #1;
    rst = 1'b1; #1;
    chk_all_zero("excf_async_rst");
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk_all_zero("excf_rst_release");

    repeat (2) next_cycle();
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush controller for the five-stage pipeline; it drives the `stall_C[3:0]` and `flush_C[3:0]` vectors consumed by the PC and by the IF/ID, ID/EX and EX/MEM pipeline registers.
- Resolves load-use hazards, multi-cycle divider (MDU) occupancy, data-memory wait states, taken branches and MEM-stage exceptions into one prioritised per-cycle control word.
- Drives the PC redirect for exception entry.

## Interface
Vector bit mapping, for both `stall_C` and `flush_C`: bit0 = PC, bit1 = IF/ID, bit2 = ID/EX, bit3 = EX/MEM.

Parameters:
- `MDU_CYCLES`, default 32: total stall cycles per divide; legal range ≥2.
- `EXC_VECTOR`, default 32'h0000_0380: exception handler address.

Ports (name, direction, width, meaning):
- `clk` in 1: the one clock.
- `rst` in 1: reset, asynchronous and active-high.
- `id_rs`, `id_rt` in 5: source registers of the instruction in ID.
- `id_uses_rt` in 1: the ID instruction reads rt.
- `id_branch_taken` in 1: branch resolved taken in ID.
- `ex_mem_read` in 1: the EX instruction is a load.
- `ex_dst_reg` in 5: EX destination register.
- `ex_mdu_start` in 1: a divide enters EX this cycle.
- `mem_req` in 1: MEM stage access is active.
- `mem_ready` in 1: data memory completes this cycle.
- `mem_exc_valid` in 1: exception detected in MEM.
- `stall_C` out 4: per-register hold.
- `flush_C` out 4: per-register clear.
- `pc_redirect` out 1: PC loads `pc_redirect_addr`.
- `pc_redirect_addr` out 32: redirect target.
- `mdu_done` out 1: divide result valid in EX.
- `mdu_abort` out 1: divide cancelled by an exception.

## Operation
- States: IDLE, MDU_WAIT, EXC_FLUSH. Outputs are combinational from state and inputs; the state and a counter of width $clog2(MDU_CYCLES) are registered.
- Stall convention: when a register's stall bit is 1 and the next bit is 0, that register inserts a bubble. When both are 1, it holds.
- Priority per cycle, highest first:
  1. Exception: `mem_exc_valid` gives `flush_C`=1110, `stall_C`=0000, `pc_redirect`=1, `pc_redirect_addr`=`EXC_VECTOR`; next state EXC_FLUSH. In MDU_WAIT, also pulse `mdu_abort` and clear the counter.
  2. Memory wait: `mem_req` && !`mem_ready` gives `stall_C`=1111.
  3. MDU: in MDU_WAIT, `stall_C`=1111.
  4. Load-use: `ex_mem_read` && `ex_dst_reg`≠0 && (`ex_dst_reg`==`id_rs` || (`id_uses_rt` && `ex_dst_reg`==`id_rt`)) gives `stall_C`=0111, i.e. a bubble into ID/EX.
  5. Branch: `id_branch_taken` gives `flush_C`=0010.
- A branch coinciding with any stall is ignored that cycle; ID re-presents it.
- IDLE with `ex_mdu_start`:
  - `stall_C`=1111 this cycle.
  - Counter loads `MDU_CYCLES`-2; go to MDU_WAIT.
  - If a memory wait is active in the same cycle, the start is still accepted.
- MDU_WAIT: the counter decrements each cycle in which no memory wait is active.
  - Counter at 0 with no memory wait: go to IDLE.
  - `mdu_done`=1 in the first cycle back in IDLE, which is also the first cycle with `stall_C[3]`=0.
- EXC_FLUSH lasts one cycle: `flush_C`=1110 again to kill the wrong-path fetch, no redirect, then IDLE. A new `mem_exc_valid` in EXC_FLUSH is ignored.
- `ex_dst_reg`==0 never creates a hazard.

## Timing
- While `rst`=1, and in the first cycle after release with quiet inputs, every output is 0: `stall_C`=0000, `flush_C`=0000, `pc_redirect`=0, `pc_redirect_addr`=0, `mdu_done`=0, `mdu_abort`=0.
- Reset asserted mid-divide or mid-EXC_FLUSH: the state returns to IDLE immediately and the counter is cleared.
- Stall and flush decisions take effect at the same clock edge on which the inputs are sampled; the hazard decision itself adds zero cycles.
- A divide with no other events costs exactly `MDU_CYCLES` stalled cycles.
- Each cycle of memory wait during a divide extends the divide by one cycle.

## Configuration
- `PIPE_CTRL_MDU_EN` defined: MDU_WAIT, the counter, `mdu_done` and `mdu_abort` are compiled in.
- Undefined: `ex_mdu_start` is ignored, `mdu_done` and `mdu_abort` are tied to 0, and the FSM has IDLE and EXC_FLUSH only.

## Structure
- The shared definitions package holds the bit-index constants (`STALL_PC`, `STALL_IFID`, `STALL_IDEX`, `STALL_EXMEM`), the state encodings and the default `EXC_VECTOR`.
- One sub-module, `hazard_detect`: purely combinational load-use comparison, output `load_use`.

## Test plan
- `ex_mem_read`=1, `ex_dst_reg`=5, `id_rs`=5 → `stall_C`=0111, `flush_C`=0000 for one cycle. Same stimulus with `ex_dst_reg`=0 → `stall_C`=0000.
- `id_branch_taken`=1 with no hazard → `flush_C`=0010. With a load-use hazard in the same cycle → `stall_C`=0111, `flush_C`=0000.
- `ex_mdu_start` pulse with `MDU_CYCLES`=4 → `stall_C`=1111 for exactly 4 cycles, then `mdu_done`=1 while `stall_C`=0000. One `mem_ready`=0 cycle inserted mid-divide → 5 stalled cycles.
- `mem_exc_valid` during MDU_WAIT → `flush_C`=1110, `pc_redirect`=1, `pc_redirect_addr`=32'h380 and `mdu_abort`=1 in that cycle; the next cycle gives `flush_C`=1110 and `pc_redirect`=0; then IDLE.
- `mem_req`=1, `mem_ready`=0 for 3 cycles alongside a load-use hazard → `stall_C`=1111 for 3 cycles, then 0111 for 1 cycle.
- `rst` asserted asynchronously mid-divide → all outputs 0 immediately; after release, `ex_mdu_start` restarts a full `MDU_CYCLES` stall.
